mem_req_ctrl: RTL and testbench

- Parametrised successor to the single-cycle request unit. Sequences instruction-fetch and data-memory requests between the datapath and the cache/memory interface.
- Holds each request until its hit arrives and generates the PC-advance strobe.
- Adds halt handling, flush of a pending data access, a stall watchdog, and saturating performance counters.
- Sits between the datapath and the I/D cache request ports.

---
 rtl/mem_req_ctrl_if.sv | 33 +++
 rtl/mem_req_ctrl.sv | 119 +++++++++++
 tb/tb_mem_req_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_if.sv
// Request/hit bus between the datapath, mem_req_ctrl and the I/D cache ports.
// Handshake: a request (imemREN/dmemREN/dmemWEN) stays high until the matching hit is seen at a rising edge.
interface mem_req_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              ihit;
  logic              dhit;
  logic              dREN;
  logic              dWEN;
  logic              halt;
  logic              flush;
  logic              imemREN;
  logic              dmemREN;
  logic              dmemWEN;
  logic              pcEN;
  logic              halted;
  logic              timeout;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] dreq_cnt;
  logic [1:0]        dbg_state;

  modport slave (
    input  ihit, dhit, dREN, dWEN, halt, flush,
    output imemREN, dmemREN, dmemWEN, pcEN, halted, timeout,
    output stall_cnt, dreq_cnt, dbg_state
  );

  modport master (
    output ihit, dhit, dREN, dWEN, halt, flush,
    input  imemREN, dmemREN, dmemWEN, pcEN, halted, timeout,
    input  stall_cnt, dreq_cnt, dbg_state
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Fetch/data request sequencer: holds each request until its hit, strobes pcEN,
// handles halt and flush, and keeps a stall watchdog plus saturating perf counters.
module mem_req_ctrl #(
  parameter int WAIT_LIMIT = 200,
  parameter int WAIT_W     = 8,
  parameter int PERF_W     = 32
) (
  input  logic           clk,
  input  logic           nRST,
  mem_req_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    DATA   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_LIMIT[WAIT_W-1:0];

  state_t            r_state;
  logic              r_imemREN;
  logic              r_dmemREN;
  logic              r_dmemWEN;
  logic              r_halted;
  logic              r_timeout;
  logic [WAIT_W-1:0] r_wd;
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_dreq_cnt;

  logic              w_pc_en;
  logic              w_stall;
  logic              w_flush_exit;
  logic              w_dreq_done;
  logic [WAIT_W-1:0] w_wd_inc;

  always_comb begin
    w_pc_en      = ((r_state == FETCH) && bus.ihit && !bus.halt && !bus.dREN && !bus.dWEN) ||
                   ((r_state == DATA) && bus.dhit && !bus.flush);
    w_stall      = ((r_state == FETCH) && !bus.ihit) || ((r_state == DATA) && !bus.dhit);
    w_flush_exit = (r_state == DATA) && bus.flush;
    w_dreq_done  = (r_state == DATA) && bus.dhit && !bus.flush;
    w_wd_inc     = r_wd + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state     <= BOOT;
      r_imemREN   <= 1'b0;
      r_dmemREN   <= 1'b0;
      r_dmemWEN   <= 1'b0;
      r_halted    <= 1'b0;
      r_timeout   <= 1'b0;
      r_wd        <= '0;
      r_stall_cnt <= '0;
      r_dreq_cnt  <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state   <= FETCH;
          r_imemREN <= 1'b1;
        end
        FETCH: begin
          if (bus.ihit) begin
            if (bus.halt) begin
              r_state   <= HALTED;
              r_imemREN <= 1'b0;
              r_halted  <= 1'b1;
            end else if (bus.dWEN) begin
              r_state   <= DATA;
              r_imemREN <= 1'b0;
              r_dmemWEN <= 1'b1;
            end else if (bus.dREN) begin
              r_state   <= DATA;
              r_imemREN <= 1'b0;
              r_dmemREN <= 1'b1;
            end
          end
        end
        DATA: begin
          if (bus.flush || bus.dhit) begin
            r_state   <= FETCH;
            r_imemREN <= 1'b1;
            r_dmemREN <= 1'b0;
            r_dmemWEN <= 1'b0;
          end
        end
        default: begin
          r_state <= HALTED;
        end
      endcase

      // Watchdog measures one request; any hit or a flush starts a new one.
      if (w_stall && !w_flush_exit) begin
        if (r_wd != LIMIT) begin
          r_wd <= w_wd_inc;
          if (w_wd_inc == LIMIT) r_timeout <= 1'b1;
        end
      end else begin
        r_wd <= '0;
      end

      if (w_stall && (r_stall_cnt != {PERF_W{1'b1}})) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (w_dreq_done && (r_dreq_cnt != {PERF_W{1'b1}})) r_dreq_cnt <= r_dreq_cnt + PERF_W'(1);
    end
  end

  assign bus.imemREN   = r_imemREN;
  assign bus.dmemREN   = r_dmemREN;
  assign bus.dmemWEN   = r_dmemWEN;
  assign bus.pcEN      = w_pc_en;
  assign bus.halted    = r_halted;
  assign bus.timeout   = r_timeout;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.dreq_cnt  = r_dreq_cnt;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: a PERF_W=32 instance for the main scenarios
// and a PERF_W=4 instance for counter saturation and mid-access reset.
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_req_ctrl_if #(.PERF_W(32)) bus ();
  mem_req_ctrl_if #(.PERF_W(4))  bus4 ();

  mem_req_ctrl #(.WAIT_LIMIT(200), .WAIT_W(8), .PERF_W(32)) u_dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  mem_req_ctrl #(.WAIT_LIMIT(200), .WAIT_W(8), .PERF_W(4)) u_dut4 (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus4)
  );

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not complete within time limit");
    $fatal(1, "time limit");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.ihit = 0;  bus.dhit = 0;  bus.dREN = 0;  bus.dWEN = 0;  bus.halt = 0;  bus.flush = 0;
    bus4.ihit = 0; bus4.dhit = 0; bus4.dREN = 0; bus4.dWEN = 0; bus4.halt = 0; bus4.flush = 0;
  endtask

  // Reset, release, and advance past BOOT so both instances sit in FETCH.
  task automatic start();
    idle_inputs();
    nRST = 0;
    cyc();
    cyc();
    nRST = 1;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 0;
    cyc();
    bus.ihit = 1;
    settle();
    n_checks++; if (bus.imemREN !== 1'b0) begin n_errors++; $display("FAIL rst_imemREN: got %b exp 0", bus.imemREN); end
    n_checks++; if (bus.dmemREN !== 1'b0) begin n_errors++; $display("FAIL rst_dmemREN: got %b exp 0", bus.dmemREN); end
    n_checks++; if (bus.dmemWEN !== 1'b0) begin n_errors++; $display("FAIL rst_dmemWEN: got %b exp 0", bus.dmemWEN); end
    n_checks++; if (bus.pcEN !== 1'b0) begin n_errors++; $display("FAIL rst_pcEN: got %b exp 0", bus.pcEN); end
    n_checks++; if (bus.halted !== 1'b0) begin n_errors++; $display("FAIL rst_halted: got %b exp 0", bus.halted); end
    n_checks++; if (bus.timeout !== 1'b0) begin n_errors++; $display("FAIL rst_timeout: got %b exp 0", bus.timeout); end
    n_checks++; if (bus.stall_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_stall_cnt: got %0d exp 0", bus.stall_cnt); end
    n_checks++; if (bus.dreq_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_dreq_cnt: got %0d exp 0", bus.dreq_cnt); end
    n_checks++; if (bus.dbg_state !== 2'd0) begin n_errors++; $display("FAIL rst_state: got %0d exp 0", bus.dbg_state); end
    bus.ihit = 0;
    nRST = 1;
    settle();
    n_checks++; if (bus.imemREN !== 1'b0) begin n_errors++; $display("FAIL boot_imemREN: got %b exp 0", bus.imemREN); end
    n_checks++; if (bus.dbg_state !== 2'd0) begin n_errors++; $display("FAIL boot_state: got %0d exp 0", bus.dbg_state); end
    cyc();
    settle();
    n_checks++; if (bus.imemREN !== 1'b1) begin n_errors++; $display("FAIL fetch1_imemREN: got %b exp 1", bus.imemREN); end
    n_checks++; if (bus.pcEN !== 1'b0) begin n_errors++; $display("FAIL fetch1_pcEN: got %b exp 0", bus.pcEN); end
    n_checks++; if (bus.dbg_state !== 2'd1) begin n_errors++; $display("FAIL fetch1_state: got %0d exp 1", bus.dbg_state); end
  endtask

  // Continues from test_reset: already in FETCH with ihit low.
  task automatic test_watchdog();
    repeat (199) cyc();
    settle();
    n_checks++; if (bus.timeout !== 1'b0) begin n_errors++; $display("FAIL wd199_timeout: got %b exp 0", bus.timeout); end
    n_checks++; if (bus.stall_cnt !== 32'd199) begin n_errors++; $display("FAIL wd199_stall: got %0d exp 199", bus.stall_cnt); end
    cyc();
    settle();
    n_checks++; if (bus.timeout !== 1'b1) begin n_errors++; $display("FAIL wd200_timeout: got %b exp 1", bus.timeout); end
    n_checks++; if (bus.stall_cnt !== 32'd200) begin n_errors++; $display("FAIL wd200_stall: got %0d exp 200", bus.stall_cnt); end
    repeat (5) cyc();
    settle();
    n_checks++; if (bus.timeout !== 1'b1) begin n_errors++; $display("FAIL wd_sticky: got %b exp 1", bus.timeout); end
    n_checks++; if (bus.stall_cnt !== 32'd205) begin n_errors++; $display("FAIL wd205_stall: got %0d exp 205", bus.stall_cnt); end
    n_checks++; if (bus.imemREN !== 1'b1) begin n_errors++; $display("FAIL wd_imemREN: got %b exp 1", bus.imemREN); end
  endtask

  task automatic test_no_access();
    start();
    bus.ihit = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++; if (bus.pcEN !== 1'b1) begin n_errors++; $display("FAIL noacc_pcEN[%0d]: got %b exp 1", i, bus.pcEN); end
      cyc();
    end
    settle();
    n_checks++; if (bus.imemREN !== 1'b1) begin n_errors++; $display("FAIL noacc_imemREN: got %b exp 1", bus.imemREN); end
    n_checks++; if ({bus.dmemREN, bus.dmemWEN} !== 2'b00) begin n_errors++; $display("FAIL noacc_dmem: got %b exp 00", {bus.dmemREN, bus.dmemWEN}); end
    n_checks++; if (bus.stall_cnt !== 32'd0) begin n_errors++; $display("FAIL noacc_stall: got %0d exp 0", bus.stall_cnt); end
    n_checks++; if (bus.timeout !== 1'b0) begin n_errors++; $display("FAIL noacc_timeout: got %b exp 0", bus.timeout); end
    bus.ihit = 0;
  endtask

  task automatic test_load();
    start();
    bus.ihit = 1; bus.dREN = 1;
    settle();
    n_checks++; if (bus.pcEN !== 1'b0) begin n_errors++; $display("FAIL load_ihit_pcEN: got %b exp 0", bus.pcEN); end
    cyc();
    bus.ihit = 0; bus.dREN = 0;
    settle();
    n_checks++; if (bus.dmemREN !== 1'b1) begin n_errors++; $display("FAIL load_dmemREN: got %b exp 1", bus.dmemREN); end
    n_checks++; if (bus.imemREN !== 1'b0) begin n_errors++; $display("FAIL load_imemREN: got %b exp 0", bus.imemREN); end
    n_checks++; if (bus.dmemWEN !== 1'b0) begin n_errors++; $display("FAIL load_dmemWEN: got %b exp 0", bus.dmemWEN); end
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++; if (bus.pcEN !== 1'b0) begin n_errors++; $display("FAIL load_wait_pcEN[%0d]: got %b exp 0", i, bus.pcEN); end
      cyc();
    end
    bus.dhit = 1;
    settle();
    n_checks++; if (bus.pcEN !== 1'b1) begin n_errors++; $display("FAIL load_dhit_pcEN: got %b exp 1", bus.pcEN); end
    n_checks++; if (bus.stall_cnt !== 32'd3) begin n_errors++; $display("FAIL load_stall: got %0d exp 3", bus.stall_cnt); end
    cyc();
    bus.dhit = 0;
    settle();
    n_checks++; if (bus.dreq_cnt !== 32'd1) begin n_errors++; $display("FAIL load_dreq: got %0d exp 1", bus.dreq_cnt); end
    n_checks++; if (bus.imemREN !== 1'b1) begin n_errors++; $display("FAIL load_after_imemREN: got %b exp 1", bus.imemREN); end
    n_checks++; if (bus.dmemREN !== 1'b0) begin n_errors++; $display("FAIL load_after_dmemREN: got %b exp 0", bus.dmemREN); end
    n_checks++; if (bus.stall_cnt !== 32'd3) begin n_errors++; $display("FAIL load_after_stall: got %0d exp 3", bus.stall_cnt); end
  endtask

  task automatic test_store_flush();
    start();
    bus.ihit = 1; bus.dREN = 1; bus.dWEN = 1;
    settle();
    n_checks++; if (bus.pcEN !== 1'b0) begin n_errors++; $display("FAIL st_ihit_pcEN: got %b exp 0", bus.pcEN); end
    cyc();
    bus.dREN = 0; bus.dWEN = 0;
    settle();
    n_checks++; if (bus.dmemWEN !== 1'b1) begin n_errors++; $display("FAIL st_dmemWEN: got %b exp 1", bus.dmemWEN); end
    n_checks++; if (bus.dmemREN !== 1'b0) begin n_errors++; $display("FAIL st_dmemREN: got %b exp 0", bus.dmemREN); end
    n_checks++; if (bus.imemREN !== 1'b0) begin n_errors++; $display("FAIL st_imemREN: got %b exp 0", bus.imemREN); end
    n_checks++; if (bus.pcEN !== 1'b0) begin n_errors++; $display("FAIL st_ihit_ignored_pcEN: got %b exp 0", bus.pcEN); end
    cyc();
    settle();
    n_checks++; if (bus.dbg_state !== 2'd2) begin n_errors++; $display("FAIL st_hold_state: got %0d exp 2", bus.dbg_state); end
    bus.ihit = 0; bus.flush = 1; bus.dhit = 1;
    settle();
    n_checks++; if (bus.pcEN !== 1'b0) begin n_errors++; $display("FAIL flush_pcEN: got %b exp 0", bus.pcEN); end
    cyc();
    bus.flush = 0; bus.dhit = 0;
    settle();
    n_checks++; if (bus.dbg_state !== 2'd1) begin n_errors++; $display("FAIL flush_state: got %0d exp 1", bus.dbg_state); end
    n_checks++; if (bus.imemREN !== 1'b1) begin n_errors++; $display("FAIL flush_imemREN: got %b exp 1", bus.imemREN); end
    n_checks++; if (bus.dmemWEN !== 1'b0) begin n_errors++; $display("FAIL flush_dmemWEN: got %b exp 0", bus.dmemWEN); end
    n_checks++; if (bus.dreq_cnt !== 32'd0) begin n_errors++; $display("FAIL flush_dreq: got %0d exp 0", bus.dreq_cnt); end
    bus.dhit = 1;
    settle();
    n_checks++; if (bus.pcEN !== 1'b0) begin n_errors++; $display("FAIL fetch_dhit_pcEN: got %b exp 0", bus.pcEN); end
    cyc();
    bus.dhit = 0;
    settle();
    n_checks++; if (bus.dbg_state !== 2'd1) begin n_errors++; $display("FAIL fetch_dhit_state: got %0d exp 1", bus.dbg_state); end
    bus.ihit = 1; bus.dWEN = 1;
    cyc();
    bus.ihit = 0; bus.dWEN = 0; bus.dhit = 1;
    settle();
    n_checks++; if (bus.pcEN !== 1'b1) begin n_errors++; $display("FAIL st_dhit_pcEN: got %b exp 1", bus.pcEN); end
    cyc();
    bus.dhit = 0;
    settle();
    n_checks++; if (bus.dreq_cnt !== 32'd1) begin n_errors++; $display("FAIL st_dreq: got %0d exp 1", bus.dreq_cnt); end
    n_checks++; if (bus.dmemWEN !== 1'b0) begin n_errors++; $display("FAIL st_done_dmemWEN: got %b exp 0", bus.dmemWEN); end
  endtask

  task automatic test_halt();
    start();
    bus.ihit = 1; bus.halt = 1; bus.dWEN = 1;
    settle();
    n_checks++; if (bus.pcEN !== 1'b0) begin n_errors++; $display("FAIL halt_ihit_pcEN: got %b exp 0", bus.pcEN); end
    cyc();
    bus.halt = 0; bus.dWEN = 0; bus.dREN = 1; bus.dhit = 1;
    settle();
    n_checks++; if (bus.halted !== 1'b1) begin n_errors++; $display("FAIL halt_halted: got %b exp 1", bus.halted); end
    n_checks++; if ({bus.imemREN, bus.dmemREN, bus.dmemWEN} !== 3'b000) begin n_errors++; $display("FAIL halt_reqs: got %b exp 000", {bus.imemREN, bus.dmemREN, bus.dmemWEN}); end
    n_checks++; if (bus.pcEN !== 1'b0) begin n_errors++; $display("FAIL halt_pcEN: got %b exp 0", bus.pcEN); end
    n_checks++; if (bus.dbg_state !== 2'd3) begin n_errors++; $display("FAIL halt_state: got %0d exp 3", bus.dbg_state); end
    repeat (3) cyc();
    settle();
    n_checks++; if (bus.halted !== 1'b1) begin n_errors++; $display("FAIL halt_stay: got %b exp 1", bus.halted); end
    n_checks++; if ({bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.pcEN} !== 4'b0000) begin n_errors++; $display("FAIL halt_stay_outs: got %b exp 0000", {bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.pcEN}); end
    n_checks++; if (bus.stall_cnt !== 32'd0) begin n_errors++; $display("FAIL halt_stall_frozen: got %0d exp 0", bus.stall_cnt); end
    n_checks++; if (bus.dreq_cnt !== 32'd0) begin n_errors++; $display("FAIL halt_dreq_frozen: got %0d exp 0", bus.dreq_cnt); end
    idle_inputs();
  endtask

  task automatic test_saturate_and_async_reset();
    start();
    repeat (14) cyc();
    settle();
    n_checks++; if (bus4.stall_cnt !== 4'd14) begin n_errors++; $display("FAIL sat14_stall: got %0d exp 14", bus4.stall_cnt); end
    repeat (6) cyc();
    settle();
    n_checks++; if (bus4.stall_cnt !== 4'd15) begin n_errors++; $display("FAIL sat20_stall: got %0d exp 15", bus4.stall_cnt); end
    bus4.ihit = 1; bus4.dREN = 1;
    cyc();
    bus4.ihit = 0; bus4.dREN = 0;
    settle();
    n_checks++; if (bus4.dmemREN !== 1'b1) begin n_errors++; $display("FAIL ar_dmemREN_before: got %b exp 1", bus4.dmemREN); end
    bus4.dhit = 1;
    nRST = 0;
    #1;
    n_checks++; if (bus4.dmemREN !== 1'b0) begin n_errors++; $display("FAIL ar_dmemREN_drop: got %b exp 0", bus4.dmemREN); end
    n_checks++; if (bus4.pcEN !== 1'b0) begin n_errors++; $display("FAIL ar_pcEN: got %b exp 0", bus4.pcEN); end
    n_checks++; if (bus4.dbg_state !== 2'd0) begin n_errors++; $display("FAIL ar_state: got %0d exp 0", bus4.dbg_state); end
    bus4.dhit = 0;
    nRST = 1;
    settle();
    n_checks++; if (bus4.imemREN !== 1'b0) begin n_errors++; $display("FAIL ar_boot_imemREN: got %b exp 0", bus4.imemREN); end
    cyc();
    settle();
    n_checks++; if (bus4.imemREN !== 1'b1) begin n_errors++; $display("FAIL ar_fetch_imemREN: got %b exp 1", bus4.imemREN); end
    n_checks++; if (bus4.dreq_cnt !== 4'd0) begin n_errors++; $display("FAIL ar_dreq: got %0d exp 0", bus4.dreq_cnt); end
  endtask

  initial begin
    idle_inputs();
    nRST = 0;
    test_reset();
    test_watchdog();
    test_no_access();
    test_load();
    test_store_flush();
    test_halt();
    test_saturate_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
